imem_load_ctrl: RTL and testbench

Controller for a single-port synchronous instruction RAM (NUM_INST x 32-bit words) that holds the program for the pipelined RISC-V core. After reset it owns the RAM and fills it from a byte-serial loader stream (little-endian words), zero-fills every unwritten word (32'b0 is the pipeline nop), then releases the core. In RUN it services fetch-stage reads using a byte-addressed PC. The PC's two low bits are ignored for indexing.

---
 rtl/imem_load_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction-RAM owner: fills the RAM from a byte-serial loader stream and
// zero-pads the rest. It then serves fetch-stage reads while the core runs.
module imem_load_ctrl #(
    parameter int NUM_INST = 128,
    parameter int ADDR_W   = $clog2(NUM_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              core_stall,
    output logic              load_done,
    output logic              err_overflow,
    input  logic [31:0]       pc,
    input  logic              fetch_req,
    output logic [31:0]       instruction,
    output logic              inst_valid,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_FILL, S_RUN} state_t;

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(NUM_INST - 1);
    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(NUM_INST);

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [31:0]         asm_q, asm_d;
    logic                wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                err_q, err_d;
    logic                load_done_q, load_done_d;
    logic                rd_pend_q, rd_pend_d;
    logic                oor_pend_q, oor_pend_d;
    logic                mis_q, mis_d;
    logic [31:0]         hold_q, hold_d;

    logic                hs;
    logic                in_range;
    logic [31:0]         byte_word;

    assign ld_ready   = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign core_stall = (state_q != S_RUN);
    assign hs         = ld_valid && ld_ready;
    assign in_range   = (pc[31:2] < 30'(NUM_INST));

    always_comb begin
        byte_word = asm_q;
        byte_word[{byte_cnt_q, 3'b000} +: 8] = ld_byte;
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        asm_d       = asm_q;
        wr_pend_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        rd_pend_d   = 1'b0;
        oor_pend_d  = 1'b0;
        mis_d       = 1'b0;
        hold_d      = hold_q;

        if (rd_pend_q) begin
            hold_d = mem_rdata;
        end else if (oor_pend_q) begin
            hold_d = 32'b0;
        end

        case (state_q)
            S_LOAD: begin
                if (hs) begin
                    if (ld_last || byte_cnt_q == 2'd3) begin
                        // Word complete (or flushed by ld_last): queue the write
                        // for next cycle so assembly of the next word continues.
                        wr_pend_d  = 1'b1;
                        wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                        wr_data_d  = byte_word;
                        word_cnt_d = word_cnt_q + 1'b1;
                        asm_d      = 32'b0;
                        byte_cnt_d = 2'd0;
                        if (ld_last) begin
                            state_d = S_FILL;
                        end else if (word_cnt_q == LAST_WORD) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        asm_d      = byte_word;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (hs) begin
                    err_d = 1'b1;
                    if (ld_last) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FILL: begin
                // The flushed partial word occupies the first FILL cycle.
                if (wr_pend_q) begin
                    if (word_cnt_q == FULL_CNT) begin
                        state_d = S_RUN;
                    end
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                if (ld_start) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    asm_d      = 32'b0;
                    err_d      = 1'b0;
                end else if (fetch_req) begin
                    rd_pend_d  = in_range;
                    oor_pend_d = !in_range;
                    mis_d      = (pc[1:0] != 2'b00);
                end
            end
        endcase

        load_done_d = (state_d == S_RUN) && (state_q != S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            byte_cnt_q  <= 2'd0;
            word_cnt_q  <= '0;
            asm_q       <= 32'b0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 32'b0;
            err_q       <= 1'b0;
            load_done_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            oor_pend_q  <= 1'b0;
            mis_q       <= 1'b0;
            hold_q      <= 32'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            asm_q       <= asm_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
            load_done_q <= load_done_d;
            rd_pend_q   <= rd_pend_d;
            oor_pend_q  <= oor_pend_d;
            mis_q       <= mis_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        mem_re = (state_q == S_RUN) && fetch_req && in_range;
        mem_we = wr_pend_q || (state_q == S_FILL);
        if (state_q == S_RUN) begin
            mem_addr = pc[ADDR_W+1:2];
        end else if (wr_pend_q) begin
            mem_addr = wr_addr_q;
        end else if (state_q == S_FILL) begin
            mem_addr = word_cnt_q[ADDR_W-1:0];
        end else begin
            mem_addr = '0;
        end
    end

    assign mem_wdata    = wr_pend_q ? wr_data_q : 32'b0;
    assign instruction  = rd_pend_q ? mem_rdata : (oor_pend_q ? 32'b0 : hold_q);
    assign inst_valid   = rd_pend_q || oor_pend_q;
    assign misaligned   = mis_q;
    assign load_done    = load_done_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl with a behavioural RAM attached.
// Expected RAM writes and fetch results are queued by stimulus, popped by a monitor.
module tb_imem_load_ctrl;

    localparam int N = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [7:0]  ld_byte = 8'h00;
    logic        ld_ready, core_stall, load_done, err_overflow;
    logic [31:0] pc = 32'h0;
    logic        fetch_req = 1'b0;
    logic [31:0] instruction;
    logic        inst_valid, misaligned;
    logic [6:0]  mem_addr;
    logic        mem_we, mem_re;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] ram [N];

    typedef struct { logic [6:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] inst; logic mis; } fe_t;
    wr_t wr_q[$];
    fe_t fe_q[$];

    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;
    wr_t  mon_w;
    fe_t  mon_f;

    always #5 clk = ~clk;

    imem_load_ctrl #(.NUM_INST(N)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
        .core_stall(core_stall), .load_done(load_done), .err_overflow(err_overflow),
        .pc(pc), .fetch_req(fetch_req), .instruction(instruction),
        .inst_valid(inst_valid), .misaligned(misaligned), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    initial begin
        for (int i = 0; i < N; i++) ram[i] = 32'hDEAD_0000 | i;
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT writes the RAM or returns a fetch.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we && mem_re) chk("we_re_exclusive", 32'(mem_re), 32'(0));
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(mon_w.addr));
                    chk("wr_data", mem_wdata, mon_w.data);
                end
            end
            if (inst_valid) begin
                if (fe_q.size() == 0) begin
                    chk("unexpected_inst_valid", instruction, 32'hFFFF_FFFF);
                end else begin
                    mon_f = fe_q.pop_front();
                    chk("instruction", instruction, mon_f.inst);
                    chk("misaligned", 32'(misaligned), 32'(mon_f.mis));
                end
            end
            if (load_done) begin
                done_cnt <= done_cnt + 1;
                chk("stall_at_done", 32'(core_stall), 32'(0));
                if (prev_done) chk("load_done_width", 32'(2), 32'(1));
            end
            prev_done <= load_done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    function automatic logic [7:0] sb(input int i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = 7'(a);
        e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic push_zeros(input int from);
        for (int w = from; w < N; w++) push_wr(w, 32'h0);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        @(negedge clk);
        chk("ld_ready", 32'(ld_ready), 32'(1));
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("load_done_seen", 32'(done_cnt - start), 32'(1));
    endtask

    task automatic fetch(input logic [31:0] p, input logic [31:0] exp_i,
                         input logic exp_m, input logic exp_re);
        fe_t e;
        e.inst = exp_i;
        e.mis  = exp_m;
        fe_q.push_back(e);
        fetch_req = 1'b1;
        pc = p;
        @(negedge clk);
        chk("mem_re", 32'(mem_re), 32'(exp_re));
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_core_stall"}, 32'(core_stall), 32'(1));
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'(1));
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(0));
        chk({tag, "_mem_re"}, 32'(mem_re), 32'(0));
        chk({tag, "_load_done"}, 32'(load_done), 32'(0));
        chk({tag, "_err"}, 32'(err_overflow), 32'(0));
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'(0));
        chk({tag, "_instruction"}, instruction, 32'h0);
        chk({tag, "_misaligned"}, 32'(misaligned), 32'(0));
    endtask

    task automatic load_prog1();
        logic [7:0] p1 [8];
        p1 = '{8'h93, 8'h02, 8'h40, 8'h00, 8'hB7, 8'h82, 8'h67, 8'h45};
        push_wr(0, 32'h0040_0293);
        push_wr(1, 32'h4567_82B7);
        push_zeros(2);
        for (int i = 0; i < 8; i++) send(p1[i], i == 7);
        wait_done(300);
    endtask

    initial begin
        logic [31:0] w0, w127;
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Test 1: two words, 126 zero fills
        load_prog1();
        fetch(32'h0, 32'h0040_0293, 1'b0, 1'b1);
        fetch(32'h1FC, 32'h0, 1'b0, 1'b1);

        // Test 2: five bytes, partial second word
        start_load();
        push_wr(0, 32'h0010_0513);
        push_wr(1, 32'h0000_00AA);
        push_zeros(2);
        send(8'h13, 1'b0); send(8'h05, 1'b0); send(8'h10, 1'b0);
        send(8'h00, 1'b0); send(8'hAA, 1'b1);
        wait_done(300);

        // Test 3: fetches, misaligned, idle hold, out of range
        fetch(32'h4, 32'h0000_00AA, 1'b0, 1'b1);
        fetch(32'h0, 32'h0010_0513, 1'b0, 1'b1);
        fetch(32'h6, 32'h0000_00AA, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("idle_inst_valid", 32'(inst_valid), 32'(0));
        chk("idle_hold", instruction, 32'h0000_00AA);
        @(posedge clk);
        #1;
        fetch(32'h200, 32'h0, 1'b0, 1'b0);
        fetch(32'h8, 32'h0, 1'b0, 1'b1);

        // Test 4: 520-byte overflow stream
        start_load();
        for (int w = 0; w < N; w++)
            push_wr(w, {sb(4*w+3), sb(4*w+2), sb(4*w+1), sb(4*w)});
        w0   = {sb(3), sb(2), sb(1), sb(0)};
        w127 = {sb(511), sb(510), sb(509), sb(508)};
        for (int i = 0; i < 520; i++) begin
            send(sb(i), i == 519);
            if (i == 511) chk("err_before_overflow", 32'(err_overflow), 32'(0));
            if (i == 512) chk("err_after_overflow", 32'(err_overflow), 32'(1));
        end
        wait_done(20);
        chk("err_sticky_run", 32'(err_overflow), 32'(1));
        fetch(32'h1FC, w127, 1'b0, 1'b1);
        fetch(32'h0, w0, 1'b0, 1'b1);

        // Test 5: ld_start together with fetch_req
        @(posedge clk);
        #1;
        ld_start  = 1'b1;
        fetch_req = 1'b1;
        pc        = 32'h0;
        @(posedge clk);
        #1;
        ld_start  = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        chk("restart_inst_valid", 32'(inst_valid), 32'(0));
        chk("restart_core_stall", 32'(core_stall), 32'(1));
        chk("restart_ld_ready", 32'(ld_ready), 32'(1));
        chk("restart_err_clear", 32'(err_overflow), 32'(0));
        @(posedge clk);
        #1;
        push_wr(0, 32'h4433_2211);
        push_zeros(1);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        wait_done(300);
        fetch(32'h4, 32'h0, 1'b0, 1'b1);
        fetch(32'h0, 32'h4433_2211, 1'b0, 1'b1);

        // Test 6: async reset mid-load and mid-fill
        start_load();
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_load");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_wr(0, 32'h0403_0201);
        push_zeros(1);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_fill");
        wr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_prog1();
        fetch(32'h4, 32'h4567_82B7, 1'b0, 1'b1);
        fetch(32'h0, 32'h0040_0293, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("wr_q_drained", 32'(wr_q.size()), 32'(0));
        chk("fe_q_drained", 32'(fe_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
